// File: rtl/ifm_load_fsm.sv
// IFM window-load sequencer: arbitrates for the IFM SRAM, streams NUM_IFM words
// in lock-step with counter_ifm for the register-write decoder, then runs the conv datapath.
module ifm_load_fsm #(
   parameter int unsigned NUM_IFM    = 10,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] ifm_base_addr,
   input  logic                  ifm_gnt,
   input  logic                  compute_done,
   output logic [3:0]            current_state,
   output logic [15:0]           counter_ifm,
   output logic                  ifm_req,
   output logic                  ifm_rd_en,
   output logic [ADDR_WIDTH-1:0] ifm_addr,
   output logic                  conv_start,
   output logic                  busy,
   output logic                  done
);

   if (NUM_IFM < 1 || NUM_IFM > 10) begin : g_bad_num_ifm
      $error("ifm_load_fsm: NUM_IFM must be in 1..10");
   end

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      REQ     = 4'd1,
      FETCH   = 4'd2,
      LOAD    = 4'd3,
      COMPUTE = 4'd4,
      DONE    = 4'd5
   } state_t;

   localparam logic [15:0] LAST_BEAT = 16'(NUM_IFM);

   state_t                state_q, state_n;
   logic [ADDR_WIDTH-1:0] base_q, base_n;
   logic [15:0]           cnt_n;
   logic                  req_n, rd_n, cs_n, busy_n, done_n;
   logic [ADDR_WIDTH-1:0] addr_n;

   assign current_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         base_q      <= '0;
         counter_ifm <= '0;
         ifm_req     <= 1'b0;
         ifm_rd_en   <= 1'b0;
         ifm_addr    <= '0;
         conv_start  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_n;
         base_q      <= base_n;
         counter_ifm <= cnt_n;
         ifm_req     <= req_n;
         ifm_rd_en   <= rd_n;
         ifm_addr    <= addr_n;
         conv_start  <= cs_n;
         busy        <= busy_n;
         done        <= done_n;
      end
   end

   // Outputs are computed for the state being entered, so each registered output
   // lines up with current_state; the read for beat k+1 is issued while beat k is visible.
   always_comb begin
      state_n = state_q;
      base_n  = base_q;
      cnt_n   = '0;
      req_n   = 1'b0;
      rd_n    = 1'b0;
      addr_n  = '0;
      cs_n    = 1'b0;
      done_n  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_n = REQ;
               base_n  = ifm_base_addr;
               req_n   = 1'b1;
            end
         end
         REQ: begin
            req_n = 1'b1;
            if (ifm_gnt) begin
               state_n = FETCH;
               rd_n    = 1'b1;
               addr_n  = base_q;
            end
         end
         FETCH, LOAD: begin
            if (state_q == LOAD && counter_ifm >= LAST_BEAT) begin
               state_n = COMPUTE;
               cs_n    = 1'b1;
            end else begin
               state_n = LOAD;
               cnt_n   = counter_ifm + 16'd1;
               req_n   = 1'b1;
               if (cnt_n < LAST_BEAT) begin
                  rd_n   = 1'b1;
                  addr_n = base_q + ADDR_WIDTH'(cnt_n);
               end
            end
         end
         COMPUTE: begin
            if (compute_done) begin
               state_n = DONE;
               done_n  = 1'b1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_ifm_load_fsm.sv
// Directed bench for ifm_load_fsm: three instances (NUM_IFM = 10, 4, 1) share clock,
// reset, grant and compute_done; each has its own start.
module tb_ifm_load_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ifm_gnt = 1'b0;
   logic        compute_done = 1'b0;
   logic [15:0] base = '0;
   logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

   logic [3:0]  st_a, st_b, st_c;
   logic [15:0] cnt_a, cnt_b, cnt_c;
   logic        req_a, req_b, req_c, rd_a, rd_b, rd_c;
   logic [15:0] addr_a, addr_b, addr_c;
   logic        cs_a, cs_b, cs_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;

   // {state, counter, req, rd_en, addr, conv_start, busy, done}
   logic [40:0] obs_a, obs_b, obs_c;
   assign obs_a = {st_a, cnt_a, req_a, rd_a, addr_a, cs_a, busy_a, done_a};
   assign obs_b = {st_b, cnt_b, req_b, rd_b, addr_b, cs_b, busy_b, done_b};
   assign obs_c = {st_c, cnt_c, req_c, rd_c, addr_c, cs_c, busy_c, done_c};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ifm_load_fsm #(.NUM_IFM(10), .ADDR_WIDTH(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .ifm_base_addr(base),
      .ifm_gnt(ifm_gnt), .compute_done(compute_done),
      .current_state(st_a), .counter_ifm(cnt_a), .ifm_req(req_a), .ifm_rd_en(rd_a),
      .ifm_addr(addr_a), .conv_start(cs_a), .busy(busy_a), .done(done_a));

   ifm_load_fsm #(.NUM_IFM(4), .ADDR_WIDTH(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .ifm_base_addr(base),
      .ifm_gnt(ifm_gnt), .compute_done(compute_done),
      .current_state(st_b), .counter_ifm(cnt_b), .ifm_req(req_b), .ifm_rd_en(rd_b),
      .ifm_addr(addr_b), .conv_start(cs_b), .busy(busy_b), .done(done_b));

   ifm_load_fsm #(.NUM_IFM(1), .ADDR_WIDTH(16)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .ifm_base_addr(base),
      .ifm_gnt(ifm_gnt), .compute_done(compute_done),
      .current_state(st_c), .counter_ifm(cnt_c), .ifm_req(req_c), .ifm_rd_en(rd_c),
      .ifm_addr(addr_c), .conv_start(cs_c), .busy(busy_c), .done(done_c));

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({obs_a, obs_b, obs_c} !== '0)
         $display("FAIL reset_hold a=%h b=%h c=%h required all 0", obs_a, obs_b, obs_c);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b, obs_c} !== '0)
         $display("FAIL reset_release a=%h b=%h c=%h required all 0", obs_a, obs_b, obs_c);
   endtask

   task automatic test_nominal();
      logic [40:0] exp;
      base = 16'h0100; ifm_gnt = 1'b1; start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      exp = {4'd1, 16'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL nominal_req got=%h exp=%h", obs_a, exp); end
      @(negedge clk);
      exp = {4'd2, 16'd0, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL nominal_fetch got=%h exp=%h", obs_a, exp); end
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         exp = {4'd3, 16'(k), 1'b1, (k < 10), (k < 10) ? 16'h0100 + 16'(k) : 16'h0000,
                1'b0, 1'b1, 1'b0};
         checks++;
         if (obs_a !== exp) begin errors++; $display("FAIL nominal_load k=%0d got=%h exp=%h", k, obs_a, exp); end
      end
      @(negedge clk);
      exp = {4'd4, 16'd0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL nominal_conv_start got=%h exp=%h", obs_a, exp); end
      @(negedge clk);
      exp = {4'd4, 16'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL nominal_compute_wait got=%h exp=%h", obs_a, exp); end
      compute_done = 1'b1;
      @(negedge clk); compute_done = 1'b0;
      exp = {4'd5, 16'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL nominal_done got=%h exp=%h", obs_a, exp); end
      @(negedge clk);
      checks++;
      if (obs_a !== '0) begin errors++; $display("FAIL nominal_idle got=%h exp=0", obs_a); end
   endtask

   task automatic test_grant_delay();
      logic [40:0] exp;
      base = 16'h2000; ifm_gnt = 1'b0; start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         exp = {4'd1, 16'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
         checks++;
         if (obs_a !== exp) begin errors++; $display("FAIL gnt_wait c=%0d got=%h exp=%h", c, obs_a, exp); end
         if (c < 7) @(negedge clk);
      end
      ifm_gnt = 1'b1;
      @(negedge clk);
      exp = {4'd2, 16'd0, 1'b1, 1'b1, 16'h2000, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL gnt_fetch got=%h exp=%h", obs_a, exp); end
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         exp = {4'd3, 16'(k), 1'b1, (k < 10), (k < 10) ? 16'h2000 + 16'(k) : 16'h0000,
                1'b0, 1'b1, 1'b0};
         checks++;
         if (obs_a !== exp) begin errors++; $display("FAIL gnt_load k=%0d got=%h exp=%h", k, obs_a, exp); end
      end
      @(negedge clk); compute_done = 1'b1;
      exp = {4'd4, 16'd0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL gnt_conv_start got=%h exp=%h", obs_a, exp); end
      @(negedge clk); compute_done = 1'b0;
      checks++;
      if (st_a !== 4'd5 || done_a !== 1'b1) begin
         errors++; $display("FAIL gnt_done state=%0d done=%b exp state=5 done=1", st_a, done_a);
      end
      @(negedge clk);
   endtask

   task automatic test_wrap();
      logic [40:0] exp;
      logic [15:0] exp_addr [1:4];
      exp_addr = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0000};
      base = 16'hFFFE; ifm_gnt = 1'b1; start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      @(negedge clk);
      exp = {4'd2, 16'd0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs_b !== exp) begin errors++; $display("FAIL wrap_fetch got=%h exp=%h", obs_b, exp); end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         exp = {4'd3, 16'(k), 1'b1, (k < 4), exp_addr[k], 1'b0, 1'b1, 1'b0};
         checks++;
         if (obs_b !== exp) begin errors++; $display("FAIL wrap_load k=%0d got=%h exp=%h", k, obs_b, exp); end
      end
      @(negedge clk); compute_done = 1'b1;
      checks++;
      if (st_b !== 4'd4 || cs_b !== 1'b1) begin
         errors++; $display("FAIL wrap_compute state=%0d conv_start=%b exp 4/1", st_b, cs_b);
      end
      @(negedge clk); compute_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_num1();
      logic [40:0] exp;
      base = 16'h0500; ifm_gnt = 1'b1; start_c = 1'b1;
      @(negedge clk); start_c = 1'b0;
      @(negedge clk);
      exp = {4'd2, 16'd0, 1'b1, 1'b1, 16'h0500, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs_c !== exp) begin errors++; $display("FAIL num1_fetch got=%h exp=%h", obs_c, exp); end
      @(negedge clk);
      exp = {4'd3, 16'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs_c !== exp) begin errors++; $display("FAIL num1_load got=%h exp=%h", obs_c, exp); end
      @(negedge clk); compute_done = 1'b1;
      exp = {4'd4, 16'd0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs_c !== exp) begin errors++; $display("FAIL num1_compute got=%h exp=%h", obs_c, exp); end
      @(negedge clk); compute_done = 1'b0;
      exp = {4'd5, 16'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs_c !== exp) begin errors++; $display("FAIL num1_done got=%h exp=%h", obs_c, exp); end
      @(negedge clk);
      checks++;
      if (obs_c !== '0) begin errors++; $display("FAIL num1_idle got=%h exp=0", obs_c); end
   endtask

   task automatic test_ignored_start();
      base = 16'h0040; ifm_gnt = 1'b1; start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start_a = (k == 3);
         checks++;
         if (st_a !== 4'd3 || cnt_a !== 16'(k)) begin
            errors++; $display("FAIL ign_load k=%0d state=%0d cnt=%0d", k, st_a, cnt_a);
         end
      end
      @(negedge clk); start_a = 1'b1;
      checks++;
      if (st_a !== 4'd4) begin errors++; $display("FAIL ign_compute state=%0d exp=4", st_a); end
      @(negedge clk); start_a = 1'b0;
      checks++;
      if (st_a !== 4'd4 || cs_a !== 1'b0) begin
         errors++; $display("FAIL ign_compute_hold state=%0d cs=%b exp 4/0", st_a, cs_a);
      end
      compute_done = 1'b1;
      @(negedge clk); compute_done = 1'b0; start_a = 1'b1;
      checks++;
      if (st_a !== 4'd5) begin errors++; $display("FAIL ign_done state=%0d exp=5", st_a); end
      @(negedge clk); start_a = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (obs_a !== '0) begin errors++; $display("FAIL ign_idle c=%0d got=%h exp=0", c, obs_a); end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_load();
      base = 16'h0300; ifm_gnt = 1'b1; start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (st_a !== 4'd3 || cnt_a !== 16'd5) begin
         errors++; $display("FAIL rst_setup state=%0d cnt=%0d exp 3/5", st_a, cnt_a);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs_a !== '0) begin errors++; $display("FAIL rst_async got=%h exp=0", obs_a); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_a !== '0) begin errors++; $display("FAIL rst_after got=%h exp=0", obs_a); end
      start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      checks++;
      if (obs_a !== {4'd1, 16'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL rst_restart got=%h exp state=1 req=1 busy=1", obs_a);
      end
      @(negedge clk);
      checks++;
      if (st_a !== 4'd2 || addr_a !== 16'h0300) begin
         errors++; $display("FAIL rst_restart_fetch state=%0d addr=%h exp 2/0300", st_a, addr_a);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_grant_delay();
      test_wrap();
      test_num1();
      test_ignored_start();
      test_reset_mid_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
